// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and pixel-command opcodes.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Also imported by the scan-out logic so both ends agree on the mapping.
package fb_pkg;

  localparam int FB_W          = 640;
  localparam int FB_H          = 480;
  localparam int WORDS_PER_ROW = 20;    // FB_W / 32
  localparam int FB_WORDS      = 9600;  // WORDS_PER_ROW * FB_H

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_FILL   = 2'b11
  } fb_op_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel (x,y) to its framebuffer word address, bit index and range flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: x_i/y_i pixel coordinates; word_o word address (0..9599 when in range);
//        bit_o bit within the word; in_range_o high when x<FB_W and y<FB_H.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]  x_i,
  input  logic [8:0]  y_i,
  output logic [13:0] word_o,
  output logic [4:0]  bit_o,
  output logic        in_range_o
);

  logic [13:0] row_base;

  // y*20 as (y<<4)+(y<<2); fits 14 bits for every in-range row.
  assign row_base   = {1'b0, y_i, 4'b0000} + {3'b000, y_i, 2'b00};
  assign word_o     = row_base + {9'd0, x_i[9:5]};
  assign bit_o      = x_i[4:0];
  assign in_range_o = (x_i < 10'(FB_W)) && (y_i < 9'(FB_H));

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel plotter: SET/CLEAR/TOGGLE by read-modify-write of one 32-bit word, FILL of the whole frame.
// Latency: pixel op writes 3 cycles after accept; FILL writes cycles 1..9600; dropped op done in cycle 1.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while busy.
// Ports: cmd_* command handshake and fields; rd_* framebuffer read port (data one cycle after rd_en);
//        wr_* framebuffer write port; done pulses when a command retires; err_count counts drops.
module fb_pixel_writer
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        done,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_FILL, S_DROP
  } state_t;

  state_t      state_q, state_d;
  fb_op_t      op_q, op_d;
  logic [13:0] word_q, word_d;
  logic [4:0]  bit_q, bit_d;
  logic        fill_q, fill_d;
  logic [13:0] cnt_q, cnt_d;
  logic [31:0] mod_q, mod_d;
  logic [15:0] err_q, err_d;

  logic [13:0] calc_word;
  logic [4:0]  calc_bit;
  logic        calc_in_range;
  logic [31:0] mask;

  fb_addr_calc u_addr_calc (
    .x_i        (cmd_x),
    .y_i        (cmd_y),
    .word_o     (calc_word),
    .bit_o      (calc_bit),
    .in_range_o (calc_in_range)
  );

  assign mask      = 32'd1 << bit_q;
  assign err_count = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SET;
      word_q  <= '0;
      bit_q   <= '0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      mod_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      err_q   <= err_d;
    end
  end

  // Memory-port outputs are decoded from state so reset forces them idle at once.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    bit_d     = bit_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    mod_d     = mod_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = fb_op_t'(cmd_op);
          word_d = calc_word;
          bit_d  = calc_bit;
          fill_d = cmd_x[0];
          if (fb_op_t'(cmd_op) == OP_FILL) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else if (calc_in_range) begin
            state_d = S_READ;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = {1'b0, word_q};
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        case (op_q)
          OP_SET:    mod_d = rd_data | mask;
          OP_CLEAR:  mod_d = rd_data & ~mask;
          OP_TOGGLE: mod_d = rd_data ^ mask;
          default:   mod_d = rd_data;
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {1'b0, word_q};
        wr_data = mod_q;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FILL: begin
        wr_en   = 1'b1;
        wr_addr = {1'b0, cnt_q};
        wr_data = {32{fill_q}};
        if (cnt_q == 14'(FB_WORDS - 1)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      S_DROP: begin
        done = 1'b1;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a behavioural framebuffer RAM.
// Latency: n/a.
// Backpressure: commands are presented only while cmd_ready is high, except the held-valid sequence.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic [15:0] err_count;

  fb_pixel_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Framebuffer model: registered read, preload port owned by the same process.
  logic [31:0] mem [0:FB_WORDS-1];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [31:0] pre_data;

  initial rd_data = '0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  int overlap = 0;
  always @(negedge clk) if (rd_en && wr_en) overlap++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Presents a command for exactly one accept edge; returns just after that edge.
  task automatic issue(input logic [1:0] op, input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    chk("ready before issue", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        pre;
    logic [31:0] init;
    logic        drop;
    logic [14:0] addr;
    logic [31:0] data;
    logic [15:0] err;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n_rd, n_wr, n_done, done_cyc, rd_cyc, wr_cyc, rdy_low, first_rdy;
    int addr_err, data_err, first_wr, last_wr;
    logic [14:0] ra, wa;
    logic [31:0] wd;
    logic [31:0] wd_arr [2];

    vt[0] = '{2'b00, 10'd37,  9'd2,   1'b1, 32'h0000_0000, 1'b0, 15'd41,   32'h0000_0020, 16'd0};
    vt[1] = '{2'b10, 10'd0,   9'd0,   1'b1, 32'hFFFF_FFFF, 1'b0, 15'd0,    32'hFFFF_FFFE, 16'd0};
    vt[2] = '{2'b10, 10'd0,   9'd0,   1'b0, 32'h0,         1'b0, 15'd0,    32'hFFFF_FFFF, 16'd0};
    vt[3] = '{2'b01, 10'd639, 9'd479, 1'b1, 32'hFFFF_FFFF, 1'b0, 15'd9599, 32'h7FFF_FFFF, 16'd0};
    vt[4] = '{2'b00, 10'd640, 9'd0,   1'b0, 32'h0,         1'b1, 15'd0,    32'h0,         16'd1};
    vt[5] = '{2'b00, 10'd0,   9'd480, 1'b0, 32'h0,         1'b1, 15'd0,    32'h0,         16'd2};
    vt[6] = '{2'b01, 10'd101, 9'd10,  1'b1, 32'hA5A5_A5A5, 1'b0, 15'd203,  32'hA5A5_A585, 16'd2};
    vt[7] = '{2'b10, 10'd319, 9'd240, 1'b1, 32'h1234_5678, 1'b0, 15'd4809, 32'h9234_5678, 16'd2};
    vt[8] = '{2'b00, 10'd64,  9'd1,   1'b1, 32'hFFFF_0000, 1'b0, 15'd22,   32'hFFFF_0001, 16'd2};
    vt[9] = '{2'b10, 10'd1023,9'd511, 1'b0, 32'h0,         1'b1, 15'd0,    32'h0,         16'd3};

    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = '0;
    cmd_y     = '0;
    pre_en    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset rd_en",     {31'd0, rd_en},     32'd0);
    chk("reset wr_en",     {31'd0, wr_en},     32'd0);
    chk("reset rd_addr",   {17'd0, rd_addr},   32'd0);
    chk("reset wr_addr",   {17'd0, wr_addr},   32'd0);
    chk("reset wr_data",   wr_data,            32'd0);
    chk("reset done",      {31'd0, done},      32'd0);
    chk("reset err_count", {16'd0, err_count}, 32'd0);

    // Table-driven single commands.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].pre) preload(vt[i].addr, vt[i].init);
      issue(vt[i].op, vt[i].x, vt[i].y);
      n_rd = 0; n_wr = 0; n_done = 0; done_cyc = 0; rd_cyc = 0; wr_cyc = 0;
      rdy_low = 0; first_rdy = 0; ra = '0; wa = '0; wd = '0;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (rd_en) begin n_rd++; rd_cyc = c; ra = rd_addr; end
        if (wr_en) begin n_wr++; wr_cyc = c; wa = wr_addr; wd = wr_data; end
        if (done)  begin n_done++; done_cyc = c; end
        if (!cmd_ready) rdy_low++;
        else if (first_rdy == 0) first_rdy = c;
      end
      chk($sformatf("v%0d done count", i), n_done, 1);
      chk($sformatf("v%0d err_count", i), {16'd0, err_count}, {16'd0, vt[i].err});
      if (vt[i].drop) begin
        chk($sformatf("v%0d drop reads", i),  n_rd, 0);
        chk($sformatf("v%0d drop writes", i), n_wr, 0);
        chk($sformatf("v%0d drop done cycle", i), done_cyc, 1);
        chk($sformatf("v%0d drop ready low", i), rdy_low, 1);
        chk($sformatf("v%0d drop ready back", i), first_rdy, 2);
      end else begin
        chk($sformatf("v%0d reads", i),  n_rd, 1);
        chk($sformatf("v%0d writes", i), n_wr, 1);
        chk($sformatf("v%0d read cycle", i), rd_cyc, 1);
        chk($sformatf("v%0d rd_addr", i), {17'd0, ra}, {17'd0, vt[i].addr});
        chk($sformatf("v%0d write cycle", i), wr_cyc, 3);
        chk($sformatf("v%0d wr_addr", i), {17'd0, wa}, {17'd0, vt[i].addr});
        chk($sformatf("v%0d wr_data", i), wd, vt[i].data);
        chk($sformatf("v%0d done cycle", i), done_cyc, 3);
        chk($sformatf("v%0d ready low", i), rdy_low, 3);
        chk($sformatf("v%0d ready back", i), first_rdy, 4);
      end
    end

    // Held cmd_valid: fields wiggled while busy are ignored; second op sees the first's write.
    preload(15'd0, 32'h0000_0000);
    @(negedge clk);
    cmd_op = 2'b10; cmd_x = 10'd2; cmd_y = 9'd0; cmd_valid = 1'b1;
    n_wr = 0; n_rd = 0; n_done = 0; wd_arr[0] = '0; wd_arr[1] = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wr_en) begin
        if (n_wr < 2) wd_arr[n_wr] = wr_data;
        n_wr++;
      end
      if (rd_en) n_rd++;
      if (done) n_done++;
      if (c >= 1 && c <= 3) cmd_x = 10'd5;
      if (c == 4) cmd_x = 10'd2;
      if (c == 8) cmd_valid = 1'b0;
    end
    chk("held writes", n_wr, 2);
    chk("held reads", n_rd, 2);
    chk("held dones", n_done, 2);
    chk("held first data", wd_arr[0], 32'h0000_0004);
    chk("held second data", wd_arr[1], 32'h0000_0000);

    // Full-screen FILL with white.
    issue(2'b11, 10'd1, 9'd0);
    n_wr = 0; n_rd = 0; n_done = 0; done_cyc = 0; first_rdy = 0;
    addr_err = 0; data_err = 0; first_wr = 0; last_wr = 0;
    for (int c = 1; c <= 9700 && first_rdy == 0; c++) begin
      @(negedge clk);
      if (wr_en) begin
        if (wr_addr != 15'(n_wr)) addr_err++;
        if (wr_data != 32'hFFFF_FFFF) data_err++;
        if (n_wr == 0) first_wr = c;
        last_wr = c;
        n_wr++;
      end
      if (rd_en) n_rd++;
      if (done) begin n_done++; done_cyc = c; end
      if (cmd_ready) first_rdy = c;
    end
    chk("fill writes", n_wr, 9600);
    chk("fill first write cycle", first_wr, 1);
    chk("fill last write cycle", last_wr, 9600);
    chk("fill addr errors", addr_err, 0);
    chk("fill data errors", data_err, 0);
    chk("fill reads", n_rd, 0);
    chk("fill dones", n_done, 1);
    chk("fill done cycle", done_cyc, 9600);
    chk("fill ready back", first_rdy, 9601);
    @(negedge clk);
    chk("fill mem[100]", mem[100], 32'hFFFF_FFFF);

    // Black FILL abandoned by reset at counter 100.
    issue(2'b11, 10'd0, 9'd0);
    n_wr = 0;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      if (wr_en) n_wr++;
    end
    chk("abort writes before reset", n_wr, 101);
    chk("abort wr_addr at reset", {17'd0, wr_addr}, 32'd100);
    reset_n = 1'b0;
    #1;
    chk("abort wr_en async", {31'd0, wr_en}, 32'd0);
    chk("abort wr_addr async", {17'd0, wr_addr}, 32'd0);
    chk("abort cmd_ready async", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_wr = 0; n_rd = 0; n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wr_en) n_wr++;
      if (rd_en) n_rd++;
      if (done) n_done++;
    end
    chk("abort writes after", n_wr, 0);
    chk("abort reads after", n_rd, 0);
    chk("abort dones after", n_done, 0);
    chk("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort err_count", {16'd0, err_count}, 32'd0);
    chk("abort mem[99]", mem[99], 32'h0000_0000);
    chk("abort mem[100]", mem[100], 32'hFFFF_FFFF);
    chk("rd/wr overlap cycles", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
